bfp_expand: RTL
===============

# bfp_expand

Block-floating-point expander: the widening counterpart to the narrowing convergent-round stage. Takes narrow signed samples grouped in frames, each frame tagged with a shift exponent on its first sample, and restores them to a wider fixed-point word by sign-extension plus left shift with saturation. Sits at the FFT output or between stages wherever a scaled, narrowed stream must return to full dynamic range.

## Interface
- IN_W, 10, input sample width (signed)
- OUT_W, 16, output sample width (signed), OUT_W >= IN_W
- EXP_W, 4, exponent width (unsigned shift, 0..2^EXP_W-1)
- FRAME_LEN, 64, samples per frame, >= 2
- clk  in  1  sole clock, rising edge
- i_init  in  1  reset; asynchronous, active-high
- i_vld  in  1  input sample valid
- i_sof  in  1  start of frame, qualified by i_vld
- i_exp  in  EXP_W  frame exponent, sampled only when i_vld & i_sof
- i_data  in  IN_W  signed input sample
- o_vld  out  1  output sample valid
- o_sof  out  1  first sample of frame, qualified by o_vld
- o_eof  out  1  last sample of frame, qualified by o_vld
- o_sat  out  1  frame saturated at least once; valid with o_eof
- o_err  out  1  one-cycle protocol error pulse
- o_data  out  OUT_W  signed expanded sample

## Operation
- States IDLE, RUN. Sample counter cnt, 0..FRAME_LEN-1, advances only on accepted samples.
- IDLE: i_vld & i_sof -> latch i_exp, accept sample, cnt=1, go RUN. i_vld & ~i_sof -> drop sample, pulse o_err, stay IDLE.
- RUN: i_vld & ~i_sof -> accept; cnt==FRAME_LEN-1 -> mark eof, cnt=0, go IDLE. i_vld & i_sof -> abort frame: pulse o_err, no o_eof for aborted frame, treat sample as SOF of new frame (latch new i_exp, cnt=1, stay RUN).
- Arithmetic: sign-extend i_data to IN_W+2^EXP_W-1 bits, shift left by frame exponent, clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Exponent for SOF sample is i_exp itself, not the latched value.
- Sticky sat flag clears at every accepted SOF, sets on any clipped sample of the frame, including the eof sample; o_sat = flag with eof sample, else 0.
- i_vld bubbles pass through as o_vld bubbles; no backpressure.

## Timing
- Latency 2 cycles: stage 1 registers shifted wide value + sof/eof/vld tags; stage 2 saturates and registers outputs.
- o_err asserts 1 cycle after the offending input cycle.
- o_sof/o_eof/o_sat accompany their sample's o_vld, never without it.
- o_data holds last value when o_vld=0.
- i_init asserted: immediately all outputs 0, state IDLE, cnt 0, sat flag 0, pipeline valids 0. Mid-frame reset discards frame; next input must be SOF.
- FRAME_LEN back-to-back: SOF may arrive the cycle after eof sample; no gap required.

## Structure
- Shared package holds saturation limit constants as functions of OUT_W and the state encoding (IDLE, RUN).
- One sub-module: sat_shift (combinational sign-extend, shift, clip, sat flag out), instantiated in stage 1/2 boundary.
- Frame FSM, counter, and pipeline registers in bfp_expand.

## Test plan
Params IN_W=10, OUT_W=16, EXP_W=4, FRAME_LEN=4.
- exp=3, samples 1,-1,511,-512 contiguous -> o_data 8,-8,4088,-4096 two cycles later; o_sof on first, o_eof on fourth, o_sat=0.
- exp=7, samples 511,-512,0,1 -> 32767,-32768,0,128; o_sat=1 with eof sample.
- exp=2 frame, SOF again after 2 samples with exp=0 -> o_err pulse 1 cycle, no o_eof for first frame; new frame 5,6,7,8 -> 5,6,7,8 with o_sof on 5.
- IDLE, i_vld=1 i_sof=0 data=100 -> o_err pulse, no o_vld.
- Frame with i_vld toggling 1,0,1,0... -> o_vld mirrors pattern delayed 2, counter advances only on valid, o_eof on 4th valid.
- i_init asserted mid-frame between clock edges -> outputs 0 before next edge; post-reset non-SOF sample -> o_err.

Source files
------------

// File: rtl/bfp_expand_pkg.sv
// Shared definitions for the block-floating-point expander: frame FSM
// encoding and output saturation limits.
package bfp_expand_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Largest positive value representable in a w-bit signed word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a w-bit signed word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/bfp_expand_sat_shift.sv
// Combinational sign-extend, left shift by the frame exponent and clip to the
// signed output range; sat_o flags a clipped sample.
module bfp_expand_sat_shift
    import bfp_expand_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = 16,
    parameter int EXP_W = 4
) (
    input  logic [IN_W-1:0]  data_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    // Full-precision width of a shifted sample; widened further when the
    // output word is the larger of the two so the clip compare stays exact.
    localparam int WIDE_W = IN_W + (2 ** EXP_W) - 1;
    localparam int CMP_W  = (WIDE_W > OUT_W) ? WIDE_W : OUT_W;

    localparam logic signed [CMP_W-1:0] LIM_MAX = CMP_W'(sat_max(OUT_W));
    localparam logic signed [CMP_W-1:0] LIM_MIN = CMP_W'(sat_min(OUT_W));

    logic signed [CMP_W-1:0] ext;
    logic signed [CMP_W-1:0] shifted;

    // Extend, shift and clip the sample.
    always_comb begin
        ext     = CMP_W'($signed(data_i));
        shifted = ext <<< exp_i;
        sat_o   = 1'b0;
        data_o  = shifted[OUT_W-1:0];
        if (shifted > LIM_MAX) begin
            sat_o  = 1'b1;
            data_o = LIM_MAX[OUT_W-1:0];
        end else if (shifted < LIM_MIN) begin
            sat_o  = 1'b1;
            data_o = LIM_MIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/bfp_expand.sv
// Block-floating-point expander: frame FSM and sample counter on the input
// side, a two-stage pipeline restoring each narrow sample to OUT_W bits.
//
// state | meaning
// IDLE  | waiting for a start-of-frame sample; non-SOF samples are dropped
// RUN   | inside a frame, counting accepted samples up to FRAME_LEN-1
module bfp_expand
    import bfp_expand_pkg::*;
#(
    parameter int IN_W      = 10,
    parameter int OUT_W     = 16,
    parameter int EXP_W     = 4,
    parameter int FRAME_LEN = 64
) (
    input  logic             clk,
    input  logic             i_init,
    input  logic             i_vld,
    input  logic             i_sof,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [IN_W-1:0]  i_data,
    output logic             o_vld,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_sat,
    output logic             o_err,
    output logic [OUT_W-1:0] o_data
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             accept, tag_sof, tag_eof, err_d;
    logic [EXP_W-1:0] eff_exp;

    logic             s1_vld_q, s1_sof_q, s1_eof_q;
    logic [IN_W-1:0]  s1_data_q;
    logic [EXP_W-1:0] s1_exp_q;

    logic [OUT_W-1:0] sat_data;
    logic             sat_hit;
    logic             sat_acc_q;

    logic             vld_q, sof_q, eof_q, osat_q, err_q;
    logic [OUT_W-1:0] data_q;

    // Frame state, sample counter and latched frame exponent.
    always_ff @(posedge clk or posedge i_init) begin
        if (i_init) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    // Next-state logic: accept/drop decision, frame tags and protocol error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        accept  = 1'b0;
        tag_sof = 1'b0;
        tag_eof = 1'b0;
        err_d   = 1'b0;
        if (i_vld) begin
            if (i_sof) begin
                // A SOF inside a frame aborts it and restarts on this sample.
                err_d   = (state_q == ST_RUN);
                accept  = 1'b1;
                tag_sof = 1'b1;
                exp_d   = i_exp;
                cnt_d   = CNT_W'(1);
                state_d = ST_RUN;
            end else if (state_q == ST_IDLE) begin
                err_d = 1'b1;
            end else begin
                accept = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    tag_eof = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // The SOF sample uses its own exponent; the latch only updates at the edge.
    assign eff_exp = tag_sof ? i_exp : exp_q;

    // Stage 1: capture the accepted sample with its exponent and frame tags.
    always_ff @(posedge clk or posedge i_init) begin
        if (i_init) begin
            s1_vld_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_data_q <= '0;
            s1_exp_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s1_sof_q <= tag_sof;
            s1_eof_q <= tag_eof;
            err_q    <= err_d;
            if (accept) begin
                s1_data_q <= i_data;
                s1_exp_q  <= eff_exp;
            end
        end
    end

    bfp_expand_sat_shift #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .EXP_W (EXP_W)
    ) u_sat_shift (
        .data_i (s1_data_q),
        .exp_i  (s1_exp_q),
        .data_o (sat_data),
        .sat_o  (sat_hit)
    );

    // Stage 2: register the clipped sample, tags and the per-frame sticky sat.
    always_ff @(posedge clk or posedge i_init) begin
        if (i_init) begin
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            osat_q    <= 1'b0;
            data_q    <= '0;
            sat_acc_q <= 1'b0;
        end else begin
            vld_q  <= s1_vld_q;
            sof_q  <= s1_vld_q & s1_sof_q;
            eof_q  <= s1_vld_q & s1_eof_q;
            osat_q <= s1_vld_q & s1_eof_q & ((sat_acc_q & ~s1_sof_q) | sat_hit);
            if (s1_vld_q) begin
                data_q    <= sat_data;
                sat_acc_q <= s1_sof_q ? sat_hit : (sat_acc_q | sat_hit);
            end
        end
    end

    assign o_vld  = vld_q;
    assign o_sof  = sof_q;
    assign o_eof  = eof_q;
    assign o_sat  = osat_q;
    assign o_err  = err_q;
    assign o_data = data_q;

endmodule
